// File: rtl/red_pitaya_ams_pwm_pkg.sv
// Shared definitions for the slow PWM DAC register bank.
// Holds the register offsets decoded on sys_addr[19:0], the CTRL bit
// positions, the bit position of channel values inside a bus word and a
// helper that returns the address of a per-channel register.
package red_pitaya_ams_pwm_pkg;

    localparam logic [19:0] REG_CTRL     = 20'h00000;
    localparam logic [19:0] REG_COMMIT   = 20'h00004;
    localparam logic [19:0] REG_RATE     = 20'h00008;
    localparam logic [19:0] REG_STATUS   = 20'h0000C;
    localparam logic [19:0] SHADOW_BASE  = 20'h00020;
    localparam logic [19:0] CURRENT_BASE = 20'h00040;

    localparam int CTRL_SYNC_BIT = 0;
    localparam int CTRL_RAMP_BIT = 1;

    // Channel values sit at [VAL_LSB +: DW] of the bus word.
    localparam int VAL_LSB = 16;

    // Address of the per-channel register k in a bank starting at base.
    function automatic logic [19:0] ch_addr(input logic [19:0] base, input int k);
        return base + 20'(4 * k);
    endfunction

endpackage

// File: rtl/red_pitaya_ams_pwm_ch.sv
// One PWM channel: shadow (bus-visible), target (what the output heads for)
// and current (the value driven to the modulator), plus the +/-1 stepper.
// Ports:
//   clk_i, rstn_i  clock, synchronous active-low reset
//   wr, wdata      shadow write strobe and value
//   commit         copy shadow to target (only meaningful while sync=1)
//   sync           1: target moves only on commit; 0: target follows shadow
//   ramp_en        1: current steps toward target on tick; 0: current follows target
//   tick           prescaler tick shared by all channels
//   shadow         shadow register value
//   current        current output value
//   busy           current differs from target
//   pending        shadow differs from target
module red_pitaya_ams_pwm_ch #(
    parameter int             DW      = 8,
    parameter logic [DW-1:0]  RST_VAL = '0
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    input  logic          wr,
    input  logic [DW-1:0] wdata,
    input  logic          commit,
    input  logic          sync,
    input  logic          ramp_en,
    input  logic          tick,
    output logic [DW-1:0] shadow,
    output logic [DW-1:0] current,
    output logic          busy,
    output logic          pending
);

    logic [DW-1:0] shadow_reg;
    logic [DW-1:0] target_reg;
    logic [DW-1:0] current_reg;
    logic [DW-1:0] current_next;

    // Stepping only ever moves toward the target, so it cannot overshoot
    // or wrap; with ramping off the output snaps to the target.
    always_comb begin
        current_next = current_reg;
        if (!ramp_en) begin
            current_next = target_reg;
        end else if (tick) begin
            if (current_reg < target_reg) begin
                current_next = current_reg + DW'(1);
            end else if (current_reg > target_reg) begin
                current_next = current_reg - DW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            shadow_reg  <= RST_VAL;
            target_reg  <= RST_VAL;
            current_reg <= RST_VAL;
        end else begin
            if (wr) begin
                shadow_reg <= wdata;
            end
            // Without sync the target tracks the shadow every cycle, so a
            // commit is redundant there and clearing sync flushes pending data.
            if (!sync || commit) begin
                target_reg <= shadow_reg;
            end
            current_reg <= current_next;
        end
    end

    assign shadow  = shadow_reg;
    assign current = current_reg;
    assign busy    = (current_reg != target_reg);
    assign pending = (shadow_reg != target_reg);

endmodule

// File: rtl/red_pitaya_ams_pwm.sv
// Register bank for the slow PWM DAC channels of the analog mixed-signal
// block. Holds CH_NUM duty values with optional staged (synchronous) update
// and optional rate-limited ramping toward the programmed value.
// Ports:
//   clk_i, rstn_i      clock, synchronous active-low reset
//   dac_o              current PWM values, channel k at [k*DW +: DW]
//   busy_o             channel k still ramping
//   sys_addr/wdata     bus address (only [19:0] decoded) and write data
//   sys_wen/ren        bus write / read strobes
//   sys_rdata/ack/err  registered read data and acknowledge, error tied low
module red_pitaya_ams_pwm
    import red_pitaya_ams_pwm_pkg::*;
#(
    parameter int                   CH_NUM  = 4,
    parameter int                   DW      = 8,
    parameter int                   RATE_W  = 16,
    parameter logic [CH_NUM*DW-1:0] DAC_RST = {8'h9C, 8'h75, 8'h4E, 8'h0F}
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    output logic [CH_NUM*DW-1:0] dac_o,
    output logic [CH_NUM-1:0]    busy_o,
    input  logic [31:0]          sys_addr,
    input  logic [31:0]          sys_wdata,
    input  logic                 sys_wen,
    input  logic                 sys_ren,
    output logic [31:0]          sys_rdata,
    output logic                 sys_err,
    output logic                 sys_ack
);

    logic [19:0]       addr;
    logic              ctrl_sync_reg;
    logic              ctrl_ramp_reg;
    logic [RATE_W-1:0] rate_reg;
    logic [RATE_W-1:0] presc_reg;
    logic [RATE_W-1:0] presc_next;
    logic              sys_ack_reg;
    logic [31:0]       sys_rdata_reg;
    logic [31:0]       rdata_next;
    logic              tick;
    logic              wr_ctrl;
    logic              wr_rate;
    logic              commit;
    logic [DW-1:0]     shadow_val  [CH_NUM];
    logic [DW-1:0]     current_val [CH_NUM];
    logic [CH_NUM-1:0] pending;
    logic              unused_bus;

    assign addr    = sys_addr[19:0];
    assign wr_ctrl = sys_wen && (addr == REG_CTRL);
    assign wr_rate = sys_wen && (addr == REG_RATE);
    assign commit  = sys_wen && (addr == REG_COMMIT) && sys_wdata[0];

    // Upper address bits and unused data bits are deliberately ignored.
    assign unused_bus = ^{sys_addr[31:20], sys_wdata};

    // Prescaler runs 0..RATE only while ramping; the tick is the wrap cycle.
    assign tick = ctrl_ramp_reg && (presc_reg == rate_reg);

    always_comb begin
        presc_next = presc_reg + RATE_W'(1);
        if (wr_rate || !ctrl_ramp_reg || tick) begin
            presc_next = '0;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < CH_NUM; gi++) begin : g_ch
            logic wr_shadow;
            assign wr_shadow = sys_wen && (addr == ch_addr(SHADOW_BASE, gi));

            red_pitaya_ams_pwm_ch #(
                .DW      (DW),
                .RST_VAL (DAC_RST[gi*DW +: DW])
            ) u_ch (
                .clk_i   (clk_i),
                .rstn_i  (rstn_i),
                .wr      (wr_shadow),
                .wdata   (sys_wdata[VAL_LSB +: DW]),
                .commit  (commit),
                .sync    (ctrl_sync_reg),
                .ramp_en (ctrl_ramp_reg),
                .tick    (tick),
                .shadow  (shadow_val[gi]),
                .current (current_val[gi]),
                .busy    (busy_o[gi]),
                .pending (pending[gi])
            );

            assign dac_o[gi*DW +: DW] = current_val[gi];
        end
    endgenerate

    // Read mux; anything not decoded (including channels >= CH_NUM) reads 0.
    always_comb begin
        rdata_next = '0;
        case (addr)
            REG_CTRL: begin
                rdata_next[CTRL_SYNC_BIT] = ctrl_sync_reg;
                rdata_next[CTRL_RAMP_BIT] = ctrl_ramp_reg;
            end
            REG_RATE: begin
                rdata_next[RATE_W-1:0] = rate_reg;
            end
            REG_STATUS: begin
                rdata_next[CH_NUM-1:0]       = busy_o;
                rdata_next[VAL_LSB +: CH_NUM] = pending;
            end
            default: begin
                for (int k = 0; k < CH_NUM; k++) begin
                    if (addr == ch_addr(SHADOW_BASE, k)) begin
                        rdata_next[VAL_LSB +: DW] = shadow_val[k];
                    end
                    if (addr == ch_addr(CURRENT_BASE, k)) begin
                        rdata_next[VAL_LSB +: DW] = current_val[k];
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            ctrl_sync_reg <= 1'b0;
            ctrl_ramp_reg <= 1'b0;
            rate_reg      <= '0;
            presc_reg     <= '0;
            sys_ack_reg   <= 1'b0;
            sys_rdata_reg <= '0;
        end else begin
            if (wr_ctrl) begin
                ctrl_sync_reg <= sys_wdata[CTRL_SYNC_BIT];
                ctrl_ramp_reg <= sys_wdata[CTRL_RAMP_BIT];
            end
            if (wr_rate) begin
                rate_reg <= sys_wdata[RATE_W-1:0];
            end
            presc_reg     <= presc_next;
            sys_ack_reg   <= sys_wen || sys_ren;
            sys_rdata_reg <= sys_ren ? rdata_next : 32'h0;
        end
    end

    assign sys_ack   = sys_ack_reg;
    assign sys_rdata = sys_rdata_reg;
    assign sys_err   = 1'b0;

endmodule

// File: tb/tb_red_pitaya_ams_pwm.sv
module tb_red_pitaya_ams_pwm;

    localparam int CH = 4;

    logic        clk_i = 1'b0;
    logic        rstn_i = 1'b0;
    logic [31:0] sys_addr = '0;
    logic [31:0] sys_wdata = '0;
    logic        sys_wen = 1'b0;
    logic        sys_ren = 1'b0;
    logic [31:0] dac_o;
    logic [3:0]  busy_o;
    logic [31:0] sys_rdata;
    logic        sys_err;
    logic        sys_ack;

    always #5 clk_i = ~clk_i;

    red_pitaya_ams_pwm #(
        .CH_NUM  (4),
        .DW      (8),
        .RATE_W  (16),
        .DAC_RST ({8'h9C, 8'h75, 8'h4E, 8'h0F})
    ) dut (
        .clk_i     (clk_i),
        .rstn_i    (rstn_i),
        .dac_o     (dac_o),
        .busy_o    (busy_o),
        .sys_addr  (sys_addr),
        .sys_wdata (sys_wdata),
        .sys_wen   (sys_wen),
        .sys_ren   (sys_ren),
        .sys_rdata (sys_rdata),
        .sys_err   (sys_err),
        .sys_ack   (sys_ack)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model: per-channel shadow/target/current as plain integers.
    int          rst_val [CH] = '{8'h0F, 8'h4E, 8'h75, 8'h9C};
    int          m_sh [CH];
    int          m_tg [CH];
    int          m_cur [CH];
    bit          m_sync, m_ramp;
    int          m_rate, m_presc;
    bit          m_ack;
    logic [31:0] m_rdata;

    function automatic logic [31:0] exp_dac();
        logic [31:0] v = '0;
        for (int k = 0; k < CH; k++) v[k*8 +: 8] = 8'(m_cur[k]);
        return v;
    endfunction

    function automatic logic [3:0] exp_busy();
        logic [3:0] v = '0;
        for (int k = 0; k < CH; k++) v[k] = (m_cur[k] != m_tg[k]);
        return v;
    endfunction

    function automatic logic [31:0] model_read(input logic [19:0] a);
        logic [31:0] v = '0;
        if (a == 20'h0) v = {30'b0, m_ramp, m_sync};
        else if (a == 20'h8) v = 32'(m_rate);
        else if (a == 20'hC) begin
            for (int k = 0; k < CH; k++) begin
                v[k]      = (m_cur[k] != m_tg[k]);
                v[16 + k] = (m_sh[k] != m_tg[k]);
            end
        end else begin
            for (int k = 0; k < CH; k++) begin
                if (a == 20'(32 + 4*k)) v = 32'(m_sh[k]) << 16;
                if (a == 20'(64 + 4*k)) v = 32'(m_cur[k]) << 16;
            end
        end
        return v;
    endfunction

    // Apply one clock edge of the rules to the model, using the inputs
    // present during the cycle that ends at that edge.
    function automatic void model_edge();
        logic [19:0] a = sys_addr[19:0];
        bit tick, commit;
        if (!rstn_i) begin
            for (int k = 0; k < CH; k++) begin
                m_sh[k] = rst_val[k]; m_tg[k] = rst_val[k]; m_cur[k] = rst_val[k];
            end
            m_sync = 0; m_ramp = 0; m_rate = 0; m_presc = 0; m_ack = 0; m_rdata = '0;
            return;
        end
        tick   = m_ramp && (m_presc == m_rate);
        commit = sys_wen && (a == 20'h4) && sys_wdata[0];
        if (sys_ren) m_rdata = model_read(a);
        for (int k = 0; k < CH; k++) begin
            if (!m_ramp) m_cur[k] = m_tg[k];
            else if (tick && m_cur[k] < m_tg[k]) m_cur[k] = m_cur[k] + 1;
            else if (tick && m_cur[k] > m_tg[k]) m_cur[k] = m_cur[k] - 1;
            if (!m_sync || commit) m_tg[k] = m_sh[k];
            if (sys_wen && a == 20'(32 + 4*k)) m_sh[k] = int'(sys_wdata[23:16]);
        end
        if (sys_wen && a == 20'h8) m_presc = 0;
        else if (!m_ramp || tick) m_presc = 0;
        else m_presc = m_presc + 1;
        if (sys_wen && a == 20'h0) begin
            m_sync = sys_wdata[0];
            m_ramp = sys_wdata[1];
        end
        if (sys_wen && a == 20'h8) m_rate = int'(sys_wdata[15:0]);
        m_ack = sys_wen || sys_ren;
    endfunction

    task automatic step();
        @(posedge clk_i);
        model_edge();
        #1;
    endtask

    task automatic idle(input int n);
        sys_wen = 1'b0;
        sys_ren = 1'b0;
        repeat (n) step();
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        sys_addr = a; sys_wdata = d; sys_wen = 1'b1; sys_ren = 1'b0;
        step();
        sys_wen = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] act,
                            output logic [31:0] expv, output logic ack);
        sys_addr = a; sys_ren = 1'b1; sys_wen = 1'b0;
        step();
        act = sys_rdata; expv = m_rdata; ack = sys_ack;
        sys_ren = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] rd, ex;
        logic ack;
        rstn_i = 1'b0;
        idle(2);
        rstn_i = 1'b1;
        checks++; if (dac_o !== 32'h9C754E0F) begin errors++; $display("FAIL reset_dac: got %h expected 9c754e0f", dac_o); end
        checks++; if (busy_o !== 4'h0) begin errors++; $display("FAIL reset_busy: got %h expected 0", busy_o); end
        checks++; if (sys_ack !== 1'b0 || sys_rdata !== 32'h0) begin errors++; $display("FAIL reset_bus: ack %b rdata %h expected 0/0", sys_ack, sys_rdata); end
        bus_read(32'h24, rd, ex, ack);
        checks++; if (rd !== 32'h004E0000 || ack !== 1'b1) begin errors++; $display("FAIL reset_read_shadow1: got %h ack %b expected 004e0000 ack 1", rd, ack); end
        bus_read(32'h0C, rd, ex, ack);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_status: got %h expected 0", rd); end
        checks++; if (sys_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", sys_err); end
        $display("reset done dac=%h", dac_o);
    endtask

    task automatic test_direct_write();
        logic [31:0] rd, ex;
        logic ack;
        bus_write(32'h20, 32'h00AB0000);
        checks++; if (sys_ack !== 1'b1) begin errors++; $display("FAIL dw_ack: got %b expected 1", sys_ack); end
        checks++; if (dac_o[7:0] !== 8'h0F) begin errors++; $display("FAIL dw_t1: got %h expected 0f", dac_o[7:0]); end
        idle(1);
        checks++; if (dac_o[7:0] !== 8'h0F || sys_ack !== 1'b0) begin errors++; $display("FAIL dw_t2: got %h ack %b expected 0f ack 0", dac_o[7:0], sys_ack); end
        idle(1);
        checks++; if (dac_o[7:0] !== 8'hAB) begin errors++; $display("FAIL dw_t3: got %h expected ab", dac_o[7:0]); end
        bus_read(32'h40, rd, ex, ack);
        checks++; if (rd !== 32'h00AB0000) begin errors++; $display("FAIL dw_read_current: got %h expected 00ab0000", rd); end
        $display("direct write ch0=ab dac=%h", dac_o);
    endtask

    task automatic test_sync_commit();
        logic [31:0] rd, ex;
        logic ack;
        bus_write(32'h0, 32'h1);
        bus_write(32'h20, 32'h00100000);
        bus_write(32'h24, 32'h00200000);
        bus_write(32'h4, 32'h2);   // bit0 clear: not a commit
        idle(4);
        checks++; if (dac_o[15:0] !== 16'h4EAB || dac_o !== exp_dac()) begin errors++; $display("FAIL sync_hold: got %h expected %h", dac_o, exp_dac()); end
        bus_read(32'h0C, rd, ex, ack);
        checks++; if (rd !== 32'h00030000) begin errors++; $display("FAIL sync_pending: got %h expected 00030000", rd); end
        bus_write(32'h4, 32'h1);
        checks++; if (dac_o[15:0] !== 16'h4EAB) begin errors++; $display("FAIL commit_t1: got %h expected 4eab", dac_o[15:0]); end
        idle(1);
        checks++; if (dac_o[15:0] !== 16'h2010) begin errors++; $display("FAIL commit_t2: got %h expected 2010", dac_o[15:0]); end
        bus_read(32'h0C, rd, ex, ack);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL commit_status: got %h expected 0", rd); end
        bus_write(32'h0, 32'h0);
        $display("sync commit dac=%h", dac_o);
    endtask

    task automatic test_ramp();
        int   t_chg[$];
        int   v_chg[$];
        logic [7:0] prev;
        bus_write(32'h20, 32'h000F0000);
        bus_write(32'h8, 32'h3);
        bus_write(32'h0, 32'h2);
        idle(4);
        checks++; if (dac_o[7:0] !== 8'h0F) begin errors++; $display("FAIL ramp_start: got %h expected 0f", dac_o[7:0]); end
        bus_write(32'h20, 32'h00120000);
        prev = dac_o[7:0];
        for (int c = 0; c < 40 && t_chg.size() < 3; c++) begin
            idle(1);
            checks++; if (dac_o !== exp_dac() || busy_o !== exp_busy()) begin errors++; $display("FAIL ramp_model: dac %h busy %h expected %h %h", dac_o, busy_o, exp_dac(), exp_busy()); end
            if (dac_o[7:0] !== prev) begin
                t_chg.push_back(c); v_chg.push_back(int'(dac_o[7:0]));
                prev = dac_o[7:0];
            end
        end
        checks++;
        if (t_chg.size() != 3) begin
            errors++; $display("FAIL ramp_steps: got %0d steps expected 3", t_chg.size());
        end else if (v_chg[0] != 'h10 || v_chg[1] != 'h11 || v_chg[2] != 'h12 ||
                     t_chg[1] - t_chg[0] != 4 || t_chg[2] - t_chg[1] != 4) begin
            errors++; $display("FAIL ramp_sequence: got %h,%h,%h gaps %0d,%0d expected 10,11,12 gaps 4,4",
                               v_chg[0], v_chg[1], v_chg[2], t_chg[1]-t_chg[0], t_chg[2]-t_chg[1]);
        end
        idle(2);
        checks++; if (busy_o[0] !== 1'b0) begin errors++; $display("FAIL ramp_done_busy: got %b expected 0", busy_o[0]); end
        $display("ramp 0f->12 dac=%h", dac_o);
    endtask

    task automatic test_retarget();
        logic [7:0] prev, at_retarget;
        int d;
        bus_write(32'h8, 32'h1);
        bus_write(32'h20, 32'h00300000);
        idle(12);
        checks++; if (busy_o[0] !== 1'b1) begin errors++; $display("FAIL retarget_busy: got %b expected 1", busy_o[0]); end
        at_retarget = dac_o[7:0];
        bus_write(32'h20, 32'h00050000);
        prev = at_retarget;
        for (int c = 0; c < 12; c++) begin
            idle(1);
            d = int'(dac_o[7:0]) - int'(prev);
            checks++; if (d > 1 || d < -1 || dac_o !== exp_dac()) begin errors++; $display("FAIL retarget_step: got %h prev %h expected %h", dac_o[7:0], prev, exp_dac()); end
            prev = dac_o[7:0];
        end
        checks++; if (dac_o[7:0] >= at_retarget) begin errors++; $display("FAIL retarget_down: got %h expected below %h", dac_o[7:0], at_retarget); end
        bus_write(32'h0, 32'h0);
        idle(1);
        checks++; if (dac_o[7:0] !== 8'h05 || busy_o !== 4'h0) begin errors++; $display("FAIL ramp_off_snap: got %h busy %h expected 05 busy 0", dac_o[7:0], busy_o); end
        $display("retarget down, ramp off dac=%h", dac_o);
    endtask

    task automatic test_unmapped();
        logic [31:0] rd, ex;
        logic ack;
        bus_read(32'h80, rd, ex, ack);
        checks++; if (rd !== 32'h0 || ack !== 1'b1 || sys_err !== 1'b0) begin errors++; $display("FAIL unmapped_read: rdata %h ack %b err %b expected 0/1/0", rd, ack, sys_err); end
        bus_write(32'h30, 32'h00770000);
        bus_write(32'h80, 32'hFFFFFFFF);
        idle(4);
        checks++; if (dac_o !== exp_dac() || sys_ack !== 1'b0) begin errors++; $display("FAIL unmapped_write: dac %h ack %b expected %h ack 0", dac_o, sys_ack, exp_dac()); end
        bus_read(32'h30, rd, ex, ack);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL shadow4_read: got %h expected 0", rd); end
        $display("unmapped accesses dac=%h", dac_o);
    endtask

    task automatic test_random();
        logic [19:0] addrs [17] = '{20'h0, 20'h4, 20'h8, 20'hC, 20'h20, 20'h24, 20'h28, 20'h2C,
                                    20'h30, 20'h40, 20'h44, 20'h48, 20'h4C, 20'h50, 20'h80,
                                    20'h10, 20'h21};
        logic [19:0] a;
        int op;
        int bad = 0;
        for (int n = 0; n < 400; n++) begin
            op = $urandom_range(0, 7);
            a  = addrs[$urandom_range(0, 16)];
            sys_addr  = ($urandom() & 32'hFFF00000) | {12'h0, a};
            sys_wdata = $urandom();
            if (a == 20'h8) sys_wdata = 32'($urandom_range(0, 3));
            sys_wen = (op >= 3 && op <= 5);
            sys_ren = (op >= 6);
            step();
            checks++;
            if (dac_o !== exp_dac() || busy_o !== exp_busy() || sys_ack !== m_ack || sys_err !== 1'b0 ||
                (sys_ren && sys_rdata !== m_rdata)) begin
                errors++; bad++;
                $display("FAIL random_cycle %0d: dac %h busy %h ack %b rdata %h expected %h %h %b %h",
                         n, dac_o, busy_o, sys_ack, sys_rdata, exp_dac(), exp_busy(), m_ack, m_rdata);
            end
        end
        idle(1);
        $display("random traffic 400 cycles, %0d bad", bad);
    endtask

    task automatic test_reset_mid_ramp();
        logic [31:0] rd, ex;
        logic ack;
        bus_write(32'h8, 32'h2);
        bus_write(32'h0, 32'h2);
        bus_write(32'h20, 32'((m_cur[0] + 'h40) & 'hFF) << 16);
        idle(5);
        checks++; if (busy_o[0] !== 1'b1) begin errors++; $display("FAIL pre_reset_busy: got %b expected 1", busy_o[0]); end
        rstn_i = 1'b0;
        sys_addr = 32'h24; sys_wdata = 32'h00550000; sys_wen = 1'b1;
        step();
        rstn_i = 1'b1; sys_wen = 1'b0;
        checks++; if (dac_o !== 32'h9C754E0F || busy_o !== 4'h0) begin errors++; $display("FAIL midreset_dac: got %h busy %h expected 9c754e0f busy 0", dac_o, busy_o); end
        checks++; if (sys_ack !== 1'b0 || sys_rdata !== 32'h0 || sys_err !== 1'b0) begin errors++; $display("FAIL midreset_bus: ack %b rdata %h err %b expected 0", sys_ack, sys_rdata, sys_err); end
        bus_read(32'h0, rd, ex, ack);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL midreset_ctrl: got %h expected 0", rd); end
        bus_read(32'h8, rd, ex, ack);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL midreset_rate: got %h expected 0", rd); end
        $display("reset mid ramp dac=%h", dac_o);
    endtask

    initial begin
        test_reset();
        test_direct_write();
        test_sync_commit();
        test_ramp();
        test_retarget();
        test_unmapped();
        test_random();
        test_reset_mid_ramp();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
